shared_memory_banked: RTL and testbench

Parametrised banked scratchpad for one SM: accepts one warp-wide request per handshake, detects bank conflicts, and replays conflicting lanes over as many passes as needed. Supports loads, byte-masked stores, and per-lane 32-bit atomic add. Sits between the LSU and per-SM scratch storage. It supersedes the fixed-width shared memory by adding:
- generic lane, bank and size parameters;
- a valid/ready request and response handshake;
- per-lane out-of-range error reporting.

---
 rtl/shared_memory_banked_pkg.sv | 29 ++
 rtl/shared_memory_banked_bank_arbiter.sv | 43 ++++
 rtl/shared_memory_banked.sv | 229 ++++++++++++++++++++++
 tb/tb_shared_memory_banked.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_memory_banked_pkg.sv
// Shared definitions for the banked shared-memory block.
//   smem_op_e    : request opcode (LOAD / STORE / ATOM_ADD; 3 is reserved, behaves as LOAD)
//   smem_state_e : controller states
//   SMEM_PASS_W  : width of the pass counter (saturates at 2**SMEM_PASS_W-1)
//   bank_of()    : bank index of a byte address for a given number of bank bits
package shared_memory_banked_pkg;

  localparam int WARP_SIZE   = 32;
  localparam int SMEM_PASS_W = 6;

  typedef enum logic [1:0] {
    SMEM_LOAD     = 2'd0,
    SMEM_STORE    = 2'd1,
    SMEM_ATOM_ADD = 2'd2,
    SMEM_RSVD     = 2'd3
  } smem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVE,
    ST_RESP
  } smem_state_e;

  // Word-interleaved banking: consecutive 32-bit words land in consecutive banks.
  function automatic logic [31:0] bank_of(input logic [31:0] addr, input int unsigned bank_bits);
    return (addr >> 2) & ((32'd1 << bank_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/shared_memory_banked_bank_arbiter.sv
// Per-bank pass arbiter (purely combinational).
//   pending      : lanes still waiting to be served
//   bank_match   : lanes whose address maps to this bank
//   lane_word    : word index within the bank, per lane
//   atomic       : request is ATOM_ADD (only the leader may be served per pass)
//   leader       : lowest-indexed pending lane in this bank
//   leader_valid : this bank has at least one pending lane
//   served       : lanes served by this bank in the current pass
module smem_bank_arbiter #(
  parameter int NUM_LANES = 32,
  parameter int WORD_W    = 7,
  parameter int LANE_W    = 5
) (
  input  logic [NUM_LANES-1:0]             pending,
  input  logic [NUM_LANES-1:0]             bank_match,
  input  logic [NUM_LANES-1:0][WORD_W-1:0] lane_word,
  input  logic                             atomic,
  output logic [LANE_W-1:0]                leader,
  output logic                             leader_valid,
  output logic [NUM_LANES-1:0]             served
);

  logic [NUM_LANES-1:0] cand;

  always_comb begin
    cand         = pending & bank_match;
    leader       = '0;
    leader_valid = 1'b0;
    // Scan downward so the last hit is the lowest index.
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (cand[i]) begin
        leader       = LANE_W'(i);
        leader_valid = 1'b1;
      end
    end
    served = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      served[i] = cand[i] && (lane_word[i] == lane_word[leader]) &&
                  (!atomic || (LANE_W'(i) == leader));
    end
  end

endmodule

// File: rtl/shared_memory_banked.sv
// Banked scratchpad for one SM. Accepts one warp-wide request per handshake,
// resolves bank conflicts by replaying lanes over successive passes, and
// returns per-lane results with conflict statistics.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake (ready only while idle)
//   req_op              : smem_op_e
//   req_mask            : active lanes
//   req_addr            : per-lane byte address (bits [1:0] ignored)
//   req_wdata           : store data or atomic addend
//   req_be              : per-lane byte enables (STORE only)
//   resp_valid/ready    : response handshake; outputs stable while waiting
//   resp_rdata          : load data or atomic old value (0 for stores / errored lanes)
//   resp_err            : lane address out of range
//   conflict_detected   : last request needed more than one pass
//   conflict_lanes      : lanes not served in the first pass
//   pass_count          : passes used by the last request (saturating)
module shared_memory_banked
  import shared_memory_banked_pkg::*;
#(
  parameter int NUM_LANES  = WARP_SIZE,
  parameter int NUM_BANKS  = 32,
  parameter int SMEM_BYTES = 16384,
  parameter int ADDR_W     = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [1:0]                           req_op,
  input  logic [NUM_LANES-1:0]                 req_mask,
  input  logic [NUM_LANES-1:0][ADDR_W-1:0]     req_addr,
  input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_LANES-1:0][3:0]            req_be,
  output logic                                 resp_valid,
  input  logic                                 resp_ready,
  output logic [NUM_LANES-1:0][DATA_WIDTH-1:0] resp_rdata,
  output logic [NUM_LANES-1:0]                 resp_err,
  output logic                                 conflict_detected,
  output logic [NUM_LANES-1:0]                 conflict_lanes,
  output logic [SMEM_PASS_W-1:0]               pass_count
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int WORDS     = SMEM_BYTES / (4 * NUM_BANKS);
  localparam int WORD_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [ADDR_W:0] SMEM_LIMIT = (ADDR_W + 1)'(SMEM_BYTES);

  function automatic logic [SMEM_PASS_W-1:0] sat_inc(input logic [SMEM_PASS_W-1:0] v);
    return (&v) ? v : v + SMEM_PASS_W'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][WORDS];

  smem_state_e                          state;
  smem_op_e                             op_q;
  logic [NUM_LANES-1:0][ADDR_W-1:0]     addr_q;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] wdata_q;
  logic [NUM_LANES-1:0][3:0]            be_q;
  logic [NUM_LANES-1:0]                 pending_q;
  logic [NUM_LANES-1:0]                 conflict_acc;
  logic [SMEM_PASS_W-1:0]               pass_cnt_q;

  logic [NUM_LANES-1:0]                 acc_pending;
  logic [NUM_LANES-1:0]                 acc_err;
  logic [NUM_LANES-1:0][BANK_BITS-1:0]  lane_bank;
  logic [NUM_LANES-1:0][WORD_W-1:0]     lane_word;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_rd;
  logic [NUM_BANKS-1:0][NUM_LANES-1:0]  bank_match;
  logic [NUM_BANKS-1:0][NUM_LANES-1:0]  served;
  logic [NUM_BANKS-1:0][LANE_W-1:0]     leader;
  logic [NUM_BANKS-1:0]                 leader_valid;
  logic [NUM_BANKS-1:0]                 wr_en;
  logic [NUM_BANKS-1:0][WORD_W-1:0]     wr_word;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] wr_data;
  logic [NUM_LANES-1:0]                 served_all;
  logic [NUM_LANES-1:0]                 remaining;
  logic                                 is_atom;
  logic                                 is_store;

  assign is_atom   = (op_q == SMEM_ATOM_ADD);
  assign is_store  = (op_q == SMEM_STORE);
  assign remaining = pending_q & ~served_all;

  // Accept-time range check on the incoming request.
  always_comb begin
    acc_pending = '0;
    acc_err     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if ({1'b0, req_addr[i]} < SMEM_LIMIT) acc_pending[i] = req_mask[i];
      else                                  acc_err[i]     = req_mask[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_bank[i] = BANK_BITS'(bank_of(32'(addr_q[i]), BANK_BITS));
      lane_word[i] = WORD_W'(addr_q[i] >> (BANK_BITS + 2));
      lane_rd[i]   = mem[lane_bank[i]][lane_word[i]];
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        bank_match[b][i] = (lane_bank[i] == BANK_BITS'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    smem_bank_arbiter #(
      .NUM_LANES (NUM_LANES),
      .WORD_W    (WORD_W),
      .LANE_W    (LANE_W)
    ) u_arb (
      .pending      (pending_q),
      .bank_match   (bank_match[b]),
      .lane_word    (lane_word),
      .atomic       (is_atom),
      .leader       (leader[b]),
      .leader_valid (leader_valid[b]),
      .served       (served[b])
    );
  end

  // Each bank writes at most one word per pass: the leader's word. Stores merge
  // served lanes in ascending order so the highest lane wins overlapping bytes.
  always_comb begin
    served_all = '0;
    wr_en      = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      served_all = served_all | served[b];
      wr_word[b] = lane_word[leader[b]];
      wr_data[b] = mem[b][wr_word[b]];
      if (state == ST_SERVE && leader_valid[b]) begin
        if (is_atom) begin
          wr_en[b]   = 1'b1;
          wr_data[b] = wr_data[b] + wdata_q[leader[b]];
        end else if (is_store) begin
          wr_en[b] = 1'b1;
          for (int i = 0; i < NUM_LANES; i++) begin
            for (int k = 0; k < 4; k++) begin
              if (served[b][i] && be_q[i][k]) wr_data[b][8*k +: 8] = wdata_q[i][8*k +: 8];
            end
          end
        end
      end
    end
  end

  // Storage: not reset; writes land at the end of their pass.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wr_en[b]) mem[b][wr_word[b]] <= wr_data[b];
    end
  end

  // Request capture: payload only, held for the whole request.
  always_ff @(posedge clk) begin
    if (req_ready && req_valid) begin
      op_q    <= smem_op_e'(req_op);
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // Controller: IDLE -> SERVE (one pass per cycle) -> RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      req_ready         <= 1'b1;
      resp_valid        <= 1'b0;
      resp_rdata        <= '0;
      resp_err          <= '0;
      conflict_detected <= 1'b0;
      conflict_lanes    <= '0;
      pass_count        <= '0;
      pending_q         <= '0;
      conflict_acc      <= '0;
      pass_cnt_q        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            pending_q    <= acc_pending;
            resp_err     <= acc_err;
            resp_rdata   <= '0;
            pass_cnt_q   <= '0;
            conflict_acc <= '0;
            req_ready    <= 1'b0;
            if (acc_pending == '0) begin
              state             <= ST_RESP;
              resp_valid        <= 1'b1;
              pass_count        <= '0;
              conflict_detected <= 1'b0;
              conflict_lanes    <= '0;
            end else begin
              state <= ST_SERVE;
            end
          end
        end
        ST_SERVE: begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (served_all[i] && !is_store) resp_rdata[i] <= lane_rd[i];
          end
          pending_q  <= remaining;
          pass_cnt_q <= sat_inc(pass_cnt_q);
          if (pass_cnt_q == '0) conflict_acc <= remaining;
          if (remaining == '0) begin
            state             <= ST_RESP;
            resp_valid        <= 1'b1;
            pass_count        <= sat_inc(pass_cnt_q);
            conflict_detected <= (pass_cnt_q != '0);
            conflict_lanes    <= (pass_cnt_q == '0) ? '0 : conflict_acc;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_memory_banked.sv
module tb_shared_memory_banked;
  import shared_memory_banked_pkg::*;

  localparam int NL = 32;
  localparam int NB = 32;
  localparam int SB = 16384;
  localparam int AW = 16;

  typedef logic [1023:0] wide_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [NL-1:0]         req_mask;
  logic [NL-1:0][AW-1:0] req_addr;
  logic [NL-1:0][31:0]   req_wdata;
  logic [NL-1:0][3:0]    req_be;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [NL-1:0][31:0]   resp_rdata;
  logic [NL-1:0]         resp_err;
  logic                  conflict_detected;
  logic [NL-1:0]         conflict_lanes;
  logic [5:0]            pass_count;

  shared_memory_banked #(
    .NUM_LANES(NL), .NUM_BANKS(NB), .SMEM_BYTES(SB), .ADDR_W(AW), .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_mask(req_mask),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .conflict_detected(conflict_detected),
    .conflict_lanes(conflict_lanes), .pass_count(pass_count)
  );

  // Reference model state: flat word-addressed memory plus the expected response.
  logic [31:0]         mmem [SB/4];
  int                  t_addr [NL];
  logic [31:0]         t_wdata [NL];
  logic [3:0]          t_be [NL];
  logic [NL-1:0][31:0] exp_rdata;
  logic [NL-1:0]       exp_err;
  logic [NL-1:0]       exp_cl;
  logic [5:0]          exp_pass;
  logic                exp_cd;
  logic                chk_en;
  int                  n_cmp = 0;
  int                  n_bad = 0;
  int                  lat;

  task automatic chk(input string name, input wide_t act, input wide_t req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic set_lane(input int i, input int a, input logic [31:0] d, input logic [3:0] be);
    t_addr[i] = a; t_wdata[i] = d; t_be[i] = be;
  endtask

  // Sequential semantics: lanes take effect in ascending order. Pass count is
  // the worst bank's number of distinct words (or lanes, for atomics).
  task automatic model(input logic [1:0] op, input logic [NL-1:0] mask);
    logic [NL-1:0] act;
    int bk [NL];
    int wd [NL];
    int p, cnt, ld;
    bit fresh;
    exp_rdata = '0; exp_err = '0; exp_cl = '0;
    for (int i = 0; i < NL; i++) begin
      act[i]     = mask[i] && (t_addr[i] < SB);
      exp_err[i] = mask[i] && !(t_addr[i] < SB);
      wd[i]      = t_addr[i] / 4;
      bk[i]      = wd[i] % NB;
    end
    for (int i = 0; i < NL; i++) begin
      if (act[i]) begin
        if (op == 2'd1) begin
          for (int k = 0; k < 4; k++)
            if (t_be[i][k]) mmem[wd[i]][8*k +: 8] = t_wdata[i][8*k +: 8];
        end else if (op == 2'd2) begin
          exp_rdata[i] = mmem[wd[i]];
          mmem[wd[i]]  = mmem[wd[i]] + t_wdata[i];
        end else begin
          exp_rdata[i] = mmem[wd[i]];
        end
      end
    end
    p = 0;
    for (int b = 0; b < NB; b++) begin
      cnt = 0;
      for (int i = 0; i < NL; i++) begin
        if (act[i] && bk[i] == b) begin
          fresh = 1'b1;
          if (op != 2'd2)
            for (int j = 0; j < i; j++)
              if (act[j] && wd[j] == wd[i]) fresh = 1'b0;
          if (fresh) cnt++;
        end
      end
      if (cnt > p) p = cnt;
    end
    exp_pass = (p > 63) ? 6'd63 : 6'(p);
    exp_cd   = (p > 1);
    for (int i = 0; i < NL; i++) begin
      if (act[i]) begin
        ld = -1;
        for (int j = 0; j < i; j++)
          if (ld < 0 && act[j] && bk[j] == bk[i]) ld = j;
        if (ld >= 0 && (op == 2'd2 || wd[ld] != wd[i])) exp_cl[i] = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [NL-1:0] mask);
    req_op = op; req_mask = mask;
    for (int i = 0; i < NL; i++) begin
      req_addr[i] = AW'(t_addr[i]); req_wdata[i] = t_wdata[i]; req_be[i] = t_be[i];
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [NL-1:0] mask, input int stall);
    int w;
    model(op, mask);
    @(negedge clk);
    drive(op, mask);
    req_valid = 1'b1;
    chk_en    = 1'b1;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    chk("req_ready_idle", wide_t'(req_ready), wide_t'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("resp_latency", wide_t'(lat), wide_t'(exp_pass));
    repeat (stall) @(negedge clk);
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("idle_after_resp", wide_t'({resp_valid, req_ready}), wide_t'(2'b01));
  endtask

  // Every cycle a response is presented, it must match the model and hold off new requests.
  always @(negedge clk) begin
    if (chk_en && rst_n && resp_valid) begin
      chk("rdata", wide_t'(resp_rdata), wide_t'(exp_rdata));
      chk("err", wide_t'(resp_err), wide_t'(exp_err));
      chk("pass_count", wide_t'(pass_count), wide_t'(exp_pass));
      chk("conflict_detected", wide_t'(conflict_detected), wide_t'(exp_cd));
      chk("conflict_lanes", wide_t'(conflict_lanes), wide_t'(exp_cl));
      chk("req_ready_busy", wide_t'(req_ready), wide_t'(0));
    end
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; chk_en = 1'b0;
    req_op = '0; req_mask = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    for (int i = 0; i < SB/4; i++) mmem[i] = '0;
    for (int i = 0; i < NL; i++) set_lane(i, 0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    chk("rst_req_ready", wide_t'(req_ready), wide_t'(1));
    chk("rst_resp_valid", wide_t'(resp_valid), wide_t'(0));
    chk("rst_rdata", wide_t'(resp_rdata), wide_t'(0));
    chk("rst_err", wide_t'(resp_err), wide_t'(0));
    chk("rst_conflict", wide_t'({conflict_detected, conflict_lanes}), wide_t'(0));
    chk("rst_pass_count", wide_t'(pass_count), wide_t'(0));
    rst_n = 1'b1;

    // Stride-4 store then load: conflict free.
    for (int i = 0; i < NL; i++) set_lane(i, i*4, 32'hA000_0000 + i, 4'hF);
    run(2'd1, '1, 0);
    chk("t1_store_pass", wide_t'(pass_count), wide_t'(1));
    chk("t1_store_latency", wide_t'(lat), wide_t'(1));
    run(2'd0, '1, 0);
    for (int i = 0; i < NL; i++) chk("t1_load_rdata", wide_t'(resp_rdata[i]), wide_t'(32'hA000_0000 + i));
    chk("t1_load_conflict", wide_t'({conflict_detected, pass_count}), wide_t'({1'b0, 6'd1}));

    // All lanes in bank 0, distinct words.
    for (int i = 0; i < NL; i++) set_lane(i, i*4*NB, 32'hB000_0000 + i, 4'hF);
    run(2'd1, '1, 0);
    chk("t2_pass", wide_t'(pass_count), wide_t'(NL));
    chk("t2_conflict_lanes", wide_t'(conflict_lanes), wide_t'(32'hFFFF_FFFE));
    chk("t2_latency", wide_t'(lat), wide_t'(NL));
    run(2'd0, '1, 0);
    for (int i = 0; i < NL; i++) chk("t2_load_rdata", wide_t'(resp_rdata[i]), wide_t'(32'hB000_0000 + i));

    // Broadcast load of one word.
    set_lane(0, 32'h200, 32'hC0DE_CAFE, 4'hF);
    run(2'd1, 32'h1, 0);
    for (int i = 0; i < NL; i++) set_lane(i, 32'h200, 32'h0, 4'h0);
    run(2'd0, '1, 0);
    for (int i = 0; i < NL; i++) chk("t3_bcast_rdata", wide_t'(resp_rdata[i]), wide_t'(32'hC0DE_CAFE));
    chk("t3_pass", wide_t'({conflict_detected, pass_count}), wide_t'({1'b0, 6'd1}));

    // Serialised atomic add on one word.
    set_lane(0, 32'h400, 32'd5, 4'hF);
    run(2'd1, 32'h1, 0);
    for (int i = 0; i < NL; i++) set_lane(i, 32'h400, 32'd1, 4'h0);
    run(2'd2, '1, 0);
    for (int i = 0; i < NL; i++) chk("t4_atom_old", wide_t'(resp_rdata[i]), wide_t'(5 + i));
    chk("t4_pass", wide_t'(pass_count), wide_t'(NL));
    run(2'd0, 32'h1, 0);
    chk("t4_final", wide_t'(resp_rdata[0]), wide_t'(5 + NL));

    // Byte-masked store plus an out-of-range lane that would alias word 0.
    set_lane(0, 0, 32'h0, 4'hF);
    run(2'd1, 32'h1, 0);
    set_lane(0, 0, 32'hFFFF_FFFF, 4'b0101);
    set_lane(1, SB, 32'h1234_5678, 4'hF);
    run(2'd1, 32'h3, 0);
    chk("t5_store_err", wide_t'(resp_err), wide_t'(32'h2));
    run(2'd0, 32'h3, 0);
    chk("t5_bytes", wide_t'(resp_rdata[0]), wide_t'(32'h00FF_00FF));
    chk("t5_err_rdata", wide_t'(resp_rdata[1]), wide_t'(0));
    chk("t5_err", wide_t'(resp_err), wide_t'(32'h2));

    // Overlapping store bytes: higher lane wins; reserved opcode reads back.
    set_lane(0, 32'h600, 32'h1111_1111, 4'hF);
    set_lane(1, 32'h600, 32'h2222_2222, 4'b0011);
    run(2'd1, 32'h3, 0);
    run(2'd3, 32'h1, 0);
    chk("overlap_merge", wide_t'(resp_rdata[0]), wide_t'(32'h1111_2222));

    // Two lanes per bank for banks 0..15: two passes.
    for (int i = 0; i < NL; i++) set_lane(i, (i % 16)*4 + (i / 16)*384, 32'hD000_0000 + i, 4'hF);
    run(2'd1, '1, 0);
    chk("two_way_pass", wide_t'(pass_count), wide_t'(2));
    chk("two_way_lanes", wide_t'(conflict_lanes), wide_t'(32'hFFFF_0000));
    run(2'd0, '1, 0);

    // Empty request responds without any pass.
    run(2'd0, '0, 0);
    chk("empty_pass", wide_t'(pass_count), wide_t'(0));
    chk("empty_latency", wide_t'(lat), wide_t'(0));

    // Response held for 5 cycles under backpressure.
    for (int i = 0; i < NL; i++) set_lane(i, i*4, 32'h0, 4'h0);
    run(2'd0, '1, 5);

    // Reset in the middle of a multi-pass load.
    chk_en = 1'b0;
    for (int i = 0; i < NL; i++) set_lane(i, i*4*NB, 32'h0, 4'h0);
    @(negedge clk);
    drive(2'd0, '1);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready", wide_t'(req_ready), wide_t'(1));
    chk("abort_resp_valid", wide_t'(resp_valid), wide_t'(0));
    chk("abort_stats", wide_t'({conflict_detected, conflict_lanes, pass_count}), wide_t'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run(2'd0, '1, 0);
    chk("after_abort_rdata5", wide_t'(resp_rdata[5]), wide_t'(32'hB000_0005));
    chk("after_abort_pass", wide_t'(pass_count), wide_t'(NL));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
